div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the MIPS execute stage, serving DIV and DIVU. It sits directly upstream of the HI/LO register file. The quotient drives the LO write data and the remainder drives the HI write data. The one-cycle `res_valid` pulse drives `res_validE`, which the HI/LO block combines with its both-halves write enable. The pipeline holds E-stage for as long as `busy` is high.

---
 rtl/div_unit.sv | 197 +++++++++++++++++++
 tb/tb_div_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Multi-cycle integer divider for the MIPS execute stage (DIV / DIVU).
//   Restoring division, one quotient bit per cycle, WIDTH iterations.
//   The quotient feeds the LO write data and the remainder feeds the HI write
//   data. res_valid is the one-cycle write strobe toward the HI/LO block.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous, active-high reset
//   start        division request, sampled only while idle
//   signed_div   1 = DIV (two's complement), 0 = DIVU; sampled with start
//   dividend     rs operand, sampled with start
//   divisor      rt operand, sampled with start
//   cancel       exception/flush; aborts any operation, beats start
//   busy         high in every state except IDLE (holds E-stage)
//   res_valid    one-cycle result strobe (DONE and not cancelled)
//   quotient     registered quotient (LO)
//   remainder    registered remainder (HI)
//   div_by_zero  registered flag for the last completed result
//   state_dbg    current FSM state (0 = IDLE, 1 = CALC, 2 = DONE)
//
// Handshake: a request is taken on the rising edge where start=1, cancel=0
// and the unit is idle (busy=0). The result is presented while res_valid=1;
// that cycle always happens, there is no downstream back-pressure. Results
// stay on quotient/remainder/div_by_zero until the next completed division.
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t state_q, state_d;

  // Iteration state
  logic [WIDTH-1:0] rem_q;   // partial remainder, always < divisor magnitude
  logic [WIDTH-1:0] dvd_q;   // dividend magnitude shifting out, quotient bits in
  logic [WIDTH-1:0] dvs_q;   // divisor magnitude
  logic             q_neg_q;
  logic             r_neg_q;
  logic [CW-1:0]    cnt_q;

  // Control strobes from the FSM
  logic accept;      // latch operands and begin iterating
  logic zero_load;   // divisor is zero: load the fixed result directly
  logic finish;      // last iteration: register sign-corrected results

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    zero_load = 1'b0;
    finish    = 1'b0;
    res_valid = 1'b0;
    busy      = (state_q != S_IDLE);
    if (cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              zero_load = 1'b1;
              state_d   = S_DONE;
            end else begin
              accept  = 1'b1;
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cnt_q == LAST_ITER) begin
            finish  = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          res_valid = 1'b1;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // Operand magnitudes (sampled on accept)
  // ---------------------------------------------------------------------------
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = signed_div & dividend[WIDTH-1];
  assign b_neg = signed_div & divisor[WIDTH-1];
  // The most negative value negates to itself, which is its correct unsigned
  // magnitude, so -2^(WIDTH-1) needs no special handling.
  assign a_mag = a_neg ? negate(dividend) : dividend;
  assign b_mag = b_neg ? negate(divisor)  : divisor;

  // ---------------------------------------------------------------------------
  // One restoring step
  // ---------------------------------------------------------------------------
  // The shifted remainder needs WIDTH+1 bits: with a divisor magnitude of up
  // to 2^WIDTH-1 the doubled remainder can exceed WIDTH bits. The trial
  // difference is one bit wider again so its MSB is a clean borrow flag.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;
  logic             unused_trial_bit;

  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {2'b00, dvs_q};
  assign borrow   = trial[WIDTH+1];
  // After a successful subtract the result is below the divisor, so it fits
  // in WIDTH bits; likewise the shifted value when the subtract borrows.
  assign rem_next = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign dvd_next = {dvd_q[WIDTH-2:0], ~borrow};
  assign unused_trial_bit = trial[WIDTH];

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (!cancel) begin
      if (accept) begin
        rem_q   <= '0;
        dvd_q   <= a_mag;
        dvs_q   <= b_mag;
        q_neg_q <= a_neg ^ b_neg;
        r_neg_q <= a_neg;
        cnt_q   <= '0;
      end
      if (zero_load) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
      if (state_q == S_CALC) begin
        rem_q <= rem_next;
        dvd_q <= dvd_next;
        cnt_q <= cnt_q + CW'(1);
      end
      if (finish) begin
        quotient    <= q_neg_q ? negate(dvd_next) : dvd_next;
        remainder   <= r_neg_q ? negate(rem_next) : rem_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit. Expected results come from plain
//   integer arithmetic on the operands (MIPS DIV/DIVU semantics plus the
//   divide-by-zero convention). Inputs change on the falling edge and outputs
//   are sampled on the falling edge; cycle N is the cycle after the N-th
//   rising edge following the start request.
// -----------------------------------------------------------------------------
module tb_div_unit;

  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_div = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         cancel = 1'b0;
  logic         busy;
  logic         res_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_div  (signed_div),
    .dividend    (dividend),
    .divisor     (divisor),
    .cancel      (cancel),
    .busy        (busy),
    .res_valid   (res_valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_dz = 1'b0;

  // Reference model: plain arithmetic division.
  task automatic ref_div(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz);
    int sa, sb;
    dz = 1'b0;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (!sd) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0;
    end else begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (call only at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic issue(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; signed_div = sd; dividend = a; divisor = b;
  endtask

  // Waits for res_valid, returning the cycle number it appeared in and whether
  // busy dropped before it did.
  task automatic wait_valid(output int lat, output bit seen, output bit gap);
    lat = 0; seen = 0; gap = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (res_valid) begin seen = 1; lat = c; end
      else if (!busy) gap = 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || quotient !== '0 ||
        remainder !== '0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset: busy=%b res_valid=%b q=%h r=%h dz=%b, required all zero",
               busy, res_valid, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: busy=%b res_valid=%b, required 0 0", busy, res_valid);
    end
  endtask

  // Directed cases then random ones, issued back to back: each new start is
  // driven in the first idle cycle after the previous result.
  task automatic test_divide();
    logic         sd_l[$];
    logic [W-1:0] a_l[$];
    logic [W-1:0] b_l[$];
    logic [W-1:0] eq, er, gq, gr;
    logic         edz;
    int           lat, exp_lat, mode;
    bit           seen, gap;
    sd_l = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    a_l  = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h1234, 32'hFFFF_FFF0, 32'h8000_0000};
    b_l  = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1,
             32'd0, 32'd0, 32'd1};
    for (int i = 0; i < 18; i++) begin
      mode = $urandom_range(0, 4);
      sd_l.push_back(1'($urandom_range(0, 1)));
      a_l.push_back($urandom);
      case (mode)
        0:       b_l.push_back(32'($urandom_range(1, 15)));
        1:       b_l.push_back(32'hFFFF_FFFF - 32'($urandom_range(0, 20)));
        2:       b_l.push_back(32'd0);
        3:       b_l.push_back(32'($urandom_range(1, 32'h0001_0000)));
        default: b_l.push_back($urandom);
      endcase
    end
    for (int i = 0; i < a_l.size(); i++) begin
      ref_div(sd_l[i], a_l[i], b_l[i], eq, er, edz);
      exp_q.push_back(eq);
      exp_q.push_back(er);
      exp_lat = edz ? 1 : 33;
      issue(sd_l[i], a_l[i], b_l[i]);
      wait_valid(lat, seen, gap);
      gq = exp_q.pop_front();
      gr = exp_q.pop_front();
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL op%0d_timeout: no res_valid within 40 cycles", i);
      end else begin
        total++;
        if (lat != exp_lat) begin
          bad++;
          $display("FAIL op%0d_latency: res_valid in cycle %0d, required %0d", i, lat, exp_lat);
        end
        total++;
        if (quotient !== gq || remainder !== gr || div_by_zero !== edz) begin
          bad++;
          $display("FAIL op%0d_result: sd=%b %h/%h got q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                   i, sd_l[i], a_l[i], b_l[i], quotient, remainder, div_by_zero, gq, gr, edz);
        end
      end
      total++;
      if (gap) begin
        bad++;
        $display("FAIL op%0d_busy: busy dropped before result, required high", i);
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || quotient !== gq || remainder !== gr) begin
        bad++;
        $display("FAIL op%0d_after: busy=%b res_valid=%b q=%h r=%h, required 0 0 %h %h",
                 i, busy, res_valid, quotient, remainder, gq, gr);
      end
      last_q = gq; last_r = gr; last_dz = edz;
    end
  endtask

  task automatic test_cancel();
    logic [W-1:0] eq, er;
    logic         edz;
    int           lat;
    bit           seen, gap, early;
    early = 0;
    issue(1'b0, 32'd50, 32'd5);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (res_valid) early = 1;
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || early) begin
      bad++;
      $display("FAIL cancel_idle: busy=%b res_valid=%b early_valid=%b, required 0 0 0",
               busy, res_valid, early);
    end
    total++;
    if (quotient !== last_q || remainder !== last_r || div_by_zero !== last_dz) begin
      bad++;
      $display("FAIL cancel_hold: q=%h r=%h dz=%b, required %h %h %b",
               quotient, remainder, div_by_zero, last_q, last_r, last_dz);
    end
    // New request in cycle 11 completes in cycle 44.
    ref_div(1'b0, 32'd50, 32'd5, eq, er, edz);
    issue(1'b0, 32'd50, 32'd5);
    wait_valid(lat, seen, gap);
    total++;
    if (!seen || lat != 33 || quotient !== eq || remainder !== er || div_by_zero !== edz) begin
      bad++;
      $display("FAIL cancel_restart: seen=%b cycle=%0d q=%h r=%h, required 1 33 %h %h",
               seen, lat, quotient, remainder, eq, er);
    end
    last_q = eq; last_r = er; last_dz = edz;
    // Cancel in the DONE cycle suppresses the strobe immediately.
    @(negedge clk);
    issue(1'b0, 32'd9, 32'd3);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    total++;
    if (res_valid !== 1'b1) begin
      bad++;
      $display("FAIL done_valid: res_valid=%b, required 1", res_valid);
    end
    cancel = 1'b1;
    #1;
    total++;
    if (res_valid !== 1'b0) begin
      bad++;
      $display("FAIL done_cancel: res_valid=%b, required 0", res_valid);
    end
    @(negedge clk);
    cancel = 1'b0;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL done_cancel_idle: busy=%b res_valid=%b, required 0 0", busy, res_valid);
    end
    last_q = 32'd3; last_r = 32'd0; last_dz = 1'b0;
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] eq, er;
    logic         edz;
    int           lat;
    bit           seen;
    seen = 0; lat = 0;
    ref_div(1'b0, 32'd1000, 32'd9, eq, er, edz);
    issue(1'b0, 32'd1000, 32'd9);
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (res_valid) begin seen = 1; lat = c; end
      if (c == 5 || c == 33) issue(1'b1, $urandom, 32'($urandom_range(1, 100)));
    end
    total++;
    if (!seen || lat != 33 || quotient !== eq || remainder !== er || div_by_zero !== edz) begin
      bad++;
      $display("FAIL ignore_start: seen=%b cycle=%0d q=%h r=%h, required 1 33 %h %h",
               seen, lat, quotient, remainder, eq, er);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1'b0 || quotient !== eq || remainder !== er) begin
        bad++;
        $display("FAIL ignore_start_idle%0d: busy=%b q=%h r=%h, required 0 %h %h",
                 c, busy, quotient, remainder, eq, er);
      end
    end
  endtask

  task automatic test_rst_mid();
    bit stray;
    stray = 0;
    issue(1'b1, 32'hDEAD_BEEF, 32'd17);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || quotient !== '0 ||
        remainder !== '0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: busy=%b res_valid=%b q=%h r=%h dz=%b, required all zero",
               busy, res_valid, quotient, remainder, div_by_zero);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid || busy) stray = 1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL rst_mid_quiet: busy or res_valid seen after reset, required none");
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    @(negedge clk);
    test_reset();
    test_divide();
    test_cancel();
    test_ignore_start();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
